bus_arbiter: RTL and testbench

- Arbitrates N serial-bus masters onto the single shared serial slave path:
  - the mode / wr_bus / master_valid / master_ready lines going to the slave;
  - the rd_bus / slave_ready / slave_valid lines returning from the slave.
- Grants use fair round-robin; the owner holds the bus until it drops its request.
- A watchdog revokes ownership from a master that goes silent.
- Sits between the master ports and the slave port in the system-bus top level.

---
 rtl/bus_arbiter.sv | 114 +++++++++++
 tb/tb_bus_arbiter.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// Round-robin arbiter muxing N serial-bus masters onto one slave path; owner holds until it drops breq.
// Grant one cycle after request, combinational data routing; watchdog revokes a silent owner.
module bus_arbiter #(
  parameter int N_MASTERS = 2,
  parameter int TIMEOUT   = 64,
  localparam int OWNER_W  = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_MASTERS-1:0] m_breq,
  output logic [N_MASTERS-1:0] m_grant,
  input  logic [N_MASTERS-1:0] m_mode,
  input  logic [N_MASTERS-1:0] m_wr_bus,
  input  logic [N_MASTERS-1:0] m_valid,
  input  logic [N_MASTERS-1:0] m_ready,
  output logic [N_MASTERS-1:0] m_rd_bus,
  output logic [N_MASTERS-1:0] m_slave_ready,
  output logic [N_MASTERS-1:0] m_slave_valid,
  output logic                 s_mode,
  output logic                 s_wr_bus,
  output logic                 s_master_valid,
  output logic                 s_master_ready,
  input  logic                 s_rd_bus,
  input  logic                 s_slave_ready,
  input  logic                 s_slave_valid,
  output logic                 bus_busy,
  output logic [OWNER_W-1:0]   owner,
  output logic                 timeout_err
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

  state_t             state, state_nxt;
  logic [OWNER_W-1:0] last_owner;
  logic [OWNER_W-1:0] pick;
  logic               pick_found;
  logic [CNT_W-1:0]   wd_cnt;
  logic               active;
  logic               wd_expire;
  int                 idx;

  // Scan starts just past the previous owner so every requester gets a turn.
  always_comb begin
    pick       = '0;
    pick_found = 1'b0;
    idx        = 0;
    for (int k = 1; k <= N_MASTERS; k++) begin
      idx = (int'(last_owner) + k) % N_MASTERS;
      if (!pick_found && m_breq[idx[OWNER_W-1:0]]) begin
        pick_found = 1'b1;
        pick       = idx[OWNER_W-1:0];
      end
    end
  end

  assign active    = m_valid[owner] | s_slave_valid;
  assign wd_expire = (wd_cnt == CNT_W'(TIMEOUT - 1)) && !active;

  always_comb begin
    state_nxt   = state;
    timeout_err = 1'b0;
    case (state)
      IDLE: begin
        if (|m_breq) state_nxt = GRANT;
      end
      GRANT: begin
        timeout_err = wd_expire;
        if (wd_expire || !m_breq[owner]) state_nxt = RELEASE;
      end
      RELEASE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= '0;
      last_owner <= OWNER_W'(N_MASTERS - 1);
      wd_cnt     <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (pick_found) owner <= pick;
          wd_cnt <= '0;
        end
        GRANT: begin
          if (state_nxt == RELEASE || active) wd_cnt <= '0;
          else                                wd_cnt <= wd_cnt + 1'b1;
        end
        RELEASE: begin
          last_owner <= owner;
          wd_cnt     <= '0;
        end
        default: wd_cnt <= '0;
      endcase
    end
  end

  // Routing is purely combinational; everything is forced low outside GRANT.
  assign bus_busy       = (state == GRANT);
  assign m_grant        = bus_busy ? (N_MASTERS'(1) << owner) : '0;
  assign s_mode         = bus_busy & m_mode[owner];
  assign s_wr_bus       = bus_busy & m_wr_bus[owner];
  assign s_master_valid = bus_busy & m_valid[owner];
  assign s_master_ready = bus_busy & m_ready[owner];
  assign m_rd_bus       = bus_busy ? (N_MASTERS'(s_rd_bus) << owner)      : '0;
  assign m_slave_ready  = bus_busy ? (N_MASTERS'(s_slave_ready) << owner) : '0;
  assign m_slave_valid  = bus_busy ? (N_MASTERS'(s_slave_valid) << owner) : '0;

endmodule

// File: tb/tb_bus_arbiter.sv
// Randomized bench for bus_arbiter with a scoreboard fed by a behavioural ownership model.
module tb_bus_arbiter;
  localparam int N  = 3;
  localparam int TO = 64;
  localparam int OW = 2;
  localparam int NCYC = 1200;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  m_breq, m_grant, m_mode, m_wr_bus, m_valid, m_ready;
  logic [N-1:0]  m_rd_bus, m_slave_ready, m_slave_valid;
  logic          s_mode, s_wr_bus, s_master_valid, s_master_ready;
  logic          s_rd_bus, s_slave_ready, s_slave_valid;
  logic          bus_busy, timeout_err;
  logic [OW-1:0] owner;

  always #5 clk = ~clk;

  bus_arbiter #(.N_MASTERS(N), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .m_breq(m_breq), .m_grant(m_grant),
    .m_mode(m_mode), .m_wr_bus(m_wr_bus), .m_valid(m_valid), .m_ready(m_ready),
    .m_rd_bus(m_rd_bus), .m_slave_ready(m_slave_ready), .m_slave_valid(m_slave_valid),
    .s_mode(s_mode), .s_wr_bus(s_wr_bus), .s_master_valid(s_master_valid),
    .s_master_ready(s_master_ready), .s_rd_bus(s_rd_bus), .s_slave_ready(s_slave_ready),
    .s_slave_valid(s_slave_valid), .bus_busy(bus_busy), .owner(owner),
    .timeout_err(timeout_err)
  );

  typedef struct {
    logic [N-1:0]  grant, rd, sr, sv;
    logic          busy, tmo, smode, swr, smv, smr;
    logic [OW-1:0] own;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: who holds the bus, whether we are in the dead release
  // cycle, how long the holder has been silent, and round-robin history.
  int holder = -1;
  bit releasing = 1'b0;
  int silent = 0;
  int last = N - 1;
  int own_m = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, want, $time);
    end
  endtask

  function automatic bit silent_expiry();
    return (holder >= 0) && !m_valid[holder] && !s_slave_valid && (silent == TO - 1);
  endfunction

  task automatic model_advance();
    if (rst) begin
      holder = -1; releasing = 1'b0; silent = 0; last = N - 1; own_m = 0;
    end else if (holder >= 0) begin
      if (silent_expiry() || !m_breq[holder]) begin
        last = holder; holder = -1; releasing = 1'b1; silent = 0;
      end else if (m_valid[holder] || s_slave_valid) silent = 0;
      else silent++;
    end else if (releasing) begin
      releasing = 1'b0;
    end else begin
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (last + k) % N;
        if (holder < 0 && m_breq[c]) begin
          holder = c; own_m = c; silent = 0;
        end
      end
    end
  endtask

  task automatic make_exp(output exp_t e);
    e.grant = '0; e.rd = '0; e.sr = '0; e.sv = '0;
    e.busy = 1'b0; e.smode = 1'b0; e.swr = 1'b0; e.smv = 1'b0; e.smr = 1'b0;
    e.own = OW'(own_m);
    e.tmo = silent_expiry();
    if (holder >= 0) begin
      e.busy = 1'b1;
      e.grant[holder] = 1'b1;
      e.smode = m_mode[holder];
      e.swr   = m_wr_bus[holder];
      e.smv   = m_valid[holder];
      e.smr   = m_ready[holder];
      e.rd[holder] = s_rd_bus;
      e.sr[holder] = s_slave_ready;
      e.sv[holder] = s_slave_valid;
    end
  endtask

  // Monitor: compares every presented cycle against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("m_grant", 32'(m_grant), 32'(e.grant));
        chk("bus_busy", 32'(bus_busy), 32'(e.busy));
        chk("owner", 32'(owner), 32'(e.own));
        chk("timeout_err", 32'(timeout_err), 32'(e.tmo));
        chk("s_mode", 32'(s_mode), 32'(e.smode));
        chk("s_wr_bus", 32'(s_wr_bus), 32'(e.swr));
        chk("s_master_valid", 32'(s_master_valid), 32'(e.smv));
        chk("s_master_ready", 32'(s_master_ready), 32'(e.smr));
        chk("m_rd_bus", 32'(m_rd_bus), 32'(e.rd));
        chk("m_slave_ready", 32'(m_slave_ready), 32'(e.sr));
        chk("m_slave_valid", 32'(m_slave_valid), 32'(e.sv));
      end
    end
  end

  // Stimulus: directed start, random contention, long silent stretches for
  // the watchdog (with periodic activity restarts), then mixed with resets.
  initial begin
    exp_t e;
    logic [N-1:0] breq_r;
    rst = 1'b1; breq_r = '0;
    m_breq = '0; m_mode = '0; m_wr_bus = '0; m_valid = '0; m_ready = '0;
    s_rd_bus = 1'b0; s_slave_ready = 1'b0; s_slave_valid = 1'b0;
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(posedge clk);
      model_advance();
      #1;
      rst = (cyc < 2) || (cyc == 450) || (cyc > 800 && $urandom_range(0, 199) == 0);
      m_mode   = N'($urandom);
      m_wr_bus = N'($urandom);
      m_ready  = N'($urandom);
      s_rd_bus      = 1'($urandom);
      s_slave_ready = 1'($urandom);
      if (cyc < 5) begin
        breq_r = '0; m_valid = '0; s_slave_valid = 1'b0;
      end else if (cyc < 40) begin
        breq_r = 3'b001; m_valid = N'($urandom); s_slave_valid = 1'($urandom);
      end else if (cyc < 250) begin
        if ($urandom_range(0, 7) == 0) breq_r[$urandom_range(0, N - 1)] ^= 1'b1;
        m_valid = N'($urandom);
        s_slave_valid = ($urandom_range(0, 3) == 0);
      end else if (cyc < 800) begin
        breq_r = (cyc % 200 < 190) ? 3'b111 : 3'b010;
        m_valid = (cyc % 97 == 40) ? 3'b111 : 3'b000;
        s_slave_valid = 1'b0;
      end else begin
        if ($urandom_range(0, 15) == 0) breq_r[$urandom_range(0, N - 1)] ^= 1'b1;
        for (int i = 0; i < N; i++) m_valid[i] = ($urandom_range(0, 40) == 0);
        s_slave_valid = ($urandom_range(0, 60) == 0);
      end
      m_breq = breq_r;
      if (!rst) begin
        make_exp(e);
        sb.push_back(e);
      end else begin
        // Reset takes effect at the next edge; this cycle still runs on old state.
        make_exp(e);
        sb.push_back(e);
      end
    end
    @(negedge clk);
    #1;
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #(20 * NCYC + 1000);
    $display("FAIL watchdog_timeout sim did not finish");
    $fatal(1);
  end
endmodule
